// File: rtl/elevator_request_latch_if.sv
// Button, service-strobe and request-summary bundle for the
// elevator request latch.
interface elevator_request_latch_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 4
);
  logic               buttons_block;
  logic [FLOORS-1:0]  btn_in;
  logic [FLOORS-1:0]  btn_up_out;
  logic [FLOORS-1:0]  btn_down_out;
  logic               arrive_valid;
  logic [FLOOR_W-1:0] arrive_floor;
  logic [1:0]         arrive_dir;
  logic [FLOOR_W-1:0] current_floor;
  logic [FLOORS-1:0]  active_in_levels;
  logic [FLOORS-1:0]  active_out_up_levels;
  logic [FLOORS-1:0]  active_out_down_levels;
  logic               any_request;
  logic               req_above;
  logic               req_below;
  logic               req_here;

  modport master (
    output buttons_block,
    output btn_in,
    output btn_up_out,
    output btn_down_out,
    output arrive_valid,
    output arrive_floor,
    output arrive_dir,
    output current_floor,
    input  active_in_levels,
    input  active_out_up_levels,
    input  active_out_down_levels,
    input  any_request,
    input  req_above,
    input  req_below,
    input  req_here
  );

  modport slave (
    input  buttons_block,
    input  btn_in,
    input  btn_up_out,
    input  btn_down_out,
    input  arrive_valid,
    input  arrive_floor,
    input  arrive_dir,
    input  current_floor,
    output active_in_levels,
    output active_out_up_levels,
    output active_out_down_levels,
    output any_request,
    output req_above,
    output req_below,
    output req_here
  );
endinterface

// File: rtl/elevator_request_latch.sv
// Button synchroniser/debouncer and request latch for an N-floor car,
// with above/below/here summaries relative to the current floor.
module elevator_request_latch_deb #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic an_reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = deb;
endmodule

module elevator_request_latch #(
  parameter int FLOORS          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FLOOR_W         = 4
) (
  input  logic clock,
  input  logic an_reset,
  elevator_request_latch_if.slave io
);
  localparam int CH = 3 * FLOORS;

  logic [FLOORS-1:0] up_raw;
  logic [FLOORS-1:0] down_raw;
  logic [CH-1:0]     raw;
  logic [CH-1:0]     deb;
  logic [CH-1:0]     prev;
  logic [CH-1:0]     press;

  logic [FLOORS-1:0] act_in;
  logic [FLOORS-1:0] act_up;
  logic [FLOORS-1:0] act_down;
  logic [FLOORS-1:0] act_in_n;
  logic [FLOORS-1:0] act_up_n;
  logic [FLOORS-1:0] act_down_n;
  logic [FLOORS-1:0] clr_mask;
  logic [FLOORS-1:0] all_act;

  // Top up and bottom down buttons do not exist on the landing.
  always_comb begin
    up_raw             = io.btn_up_out;
    up_raw[FLOORS-1]   = 1'b0;
    down_raw           = io.btn_down_out;
    down_raw[0]        = 1'b0;
  end

  assign raw = {down_raw, up_raw, io.btn_in};

  for (genvar c = 0; c < CH; c++) begin : g_ch
    elevator_request_latch_deb #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock   (clock),
      .an_reset(an_reset),
      .raw     (raw[c]),
      .level   (deb[c])
    );
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) prev <= '0;
    else           prev <= deb;
  end

  assign press = io.buttons_block ? '0 : (deb & ~prev);

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      clr_mask[i] = io.arrive_valid &&
                    (io.arrive_floor == FLOOR_W'(i));
    end
  end

  // Clears are applied after presses so a same-cycle clear wins.
  always_comb begin
    act_in_n   = act_in ^ press[FLOORS-1:0];
    act_up_n   = act_up | press[2*FLOORS-1:FLOORS];
    act_down_n = act_down | press[CH-1:2*FLOORS];
    act_in_n   = act_in_n & ~clr_mask;
    if (io.arrive_dir[0]) act_up_n = act_up_n & ~clr_mask;
    if (io.arrive_dir[1]) act_down_n = act_down_n & ~clr_mask;
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      act_in   <= '0;
      act_up   <= '0;
      act_down <= '0;
    end else begin
      act_in   <= act_in_n;
      act_up   <= act_up_n;
      act_down <= act_down_n;
    end
  end

  assign all_act = act_in | act_up | act_down;

  // Out-of-range floor naturally yields above=0, here=0, below=any.
  always_comb begin
    io.req_above = 1'b0;
    io.req_below = 1'b0;
    io.req_here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(io.current_floor))
        io.req_above = io.req_above | all_act[i];
      if (i < int'(io.current_floor))
        io.req_below = io.req_below | all_act[i];
      if (i == int'(io.current_floor))
        io.req_here = io.req_here | all_act[i];
    end
  end

  assign io.any_request            = |all_act;
  assign io.active_in_levels       = act_in;
  assign io.active_out_up_levels   = act_up;
  assign io.active_out_down_levels = act_down;
endmodule

// File: tb/tb_elevator_request_latch.sv
// Directed bench for elevator_request_latch, FLOORS=8,
// DEBOUNCE_CYCLES=4.
module tb_elevator_request_latch;
  logic clock;
  logic an_reset;
  int   checks;
  int   errors;

  elevator_request_latch_if #(.FLOORS(8), .FLOOR_W(4)) bus ();

  elevator_request_latch #(
    .FLOORS(8),
    .DEBOUNCE_CYCLES(4),
    .FLOOR_W(4)
  ) dut (
    .clock   (clock),
    .an_reset(an_reset),
    .io      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0 = cabin, 1 = landing up, 2 = landing down
  task automatic press(input int kind, input int f);
    case (kind)
      0: bus.btn_in[f] = 1'b1;
      1: bus.btn_up_out[f] = 1'b1;
      default: bus.btn_down_out[f] = 1'b1;
    endcase
    tick(6);
    bus.btn_in       = '0;
    bus.btn_up_out   = '0;
    bus.btn_down_out = '0;
    tick(10);
  endtask

  task automatic arrive(input int f, input logic [1:0] dir);
    bus.arrive_valid = 1'b1;
    bus.arrive_floor = 4'(f);
    bus.arrive_dir   = dir;
    tick(1);
    bus.arrive_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] ein,
                         input logic [7:0] eup,
                         input logic [7:0] edn);
    chk({tag, "_in"}, 32'(bus.active_in_levels), 32'(ein));
    chk({tag, "_up"}, 32'(bus.active_out_up_levels), 32'(eup));
    chk({tag, "_dn"}, 32'(bus.active_out_down_levels), 32'(edn));
    chk({tag, "_any"}, 32'(bus.any_request),
        32'(|(ein | eup | edn)));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    an_reset          = 1'b0;
    bus.buttons_block = 1'b0;
    bus.btn_in        = '0;
    bus.btn_up_out    = '0;
    bus.btn_down_out  = '0;
    bus.arrive_valid  = 1'b0;
    bus.arrive_floor  = '0;
    bus.arrive_dir    = '0;
    bus.current_floor = '0;

    tick(3);
    chk_all("rst_hold", 8'h00, 8'h00, 8'h00);
    an_reset = 1'b1;
    tick(2);
    chk_all("rst_rel", 8'h00, 8'h00, 8'h00);
    chk("rst_above", 32'(bus.req_above), 32'd0);

    // Latency: bit set exactly after edge 7
    bus.btn_in[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk($sformatf("lat_e%0d", e), 32'(bus.active_in_levels),
          (e >= 7) ? 32'h08 : 32'h00);
    end
    bus.btn_in = '0;
    tick(10);
    chk("lat_hold", 32'(bus.active_in_levels), 32'h08);

    // Short glitch, then real landing presses
    bus.btn_up_out[2] = 1'b1;
    tick(3);
    bus.btn_up_out = '0;
    tick(10);
    chk("glitch", 32'(bus.active_out_up_levels), 32'h00);
    press(1, 2);
    chk("up_set", 32'(bus.active_out_up_levels), 32'h04);
    press(1, 2);
    chk("up_again", 32'(bus.active_out_up_levels), 32'h04);
    press(1, 7);
    press(2, 0);
    chk_all("tied_off", 8'h08, 8'h04, 8'h00);

    // Cabin toggle and blocking
    press(0, 5);
    chk("tog_on", 32'(bus.active_in_levels), 32'h28);
    press(0, 5);
    chk("tog_off", 32'(bus.active_in_levels), 32'h08);
    press(0, 5);
    chk("tog_on2", 32'(bus.active_in_levels), 32'h28);
    bus.buttons_block = 1'b1;
    press(0, 5);
    bus.buttons_block = 1'b0;
    tick(2);
    chk("blocked", 32'(bus.active_in_levels), 32'h28);

    // Directional clears
    press(0, 6);
    press(2, 6);
    chk_all("pre_clr", 8'h68, 8'h04, 8'h40);
    arrive(6, 2'b01);
    chk_all("clr_up", 8'h28, 8'h04, 8'h40);
    arrive(6, 2'b10);
    chk_all("clr_dn", 8'h28, 8'h04, 8'h00);

    // Clear coincides with press event on floor 4
    bus.btn_in[4] = 1'b1;
    tick(6);
    arrive(4, 2'b11);
    chk("clr_wins", 32'(bus.active_in_levels), 32'h28);
    bus.btn_in = '0;
    tick(10);
    chk("clr_wins2", 32'(bus.active_in_levels), 32'h28);
    arrive(9, 2'b11);
    chk_all("oob_clr", 8'h28, 8'h04, 8'h00);

    // Summaries with requests at floors 1 and 6
    arrive(2, 2'b11);
    arrive(3, 2'b11);
    arrive(5, 2'b11);
    chk_all("cleared", 8'h00, 8'h00, 8'h00);
    press(0, 1);
    press(1, 6);
    chk_all("sum_set", 8'h02, 8'h40, 8'h00);
    bus.current_floor = 4'd3;
    #1;
    chk("f3_above", 32'(bus.req_above), 32'd1);
    chk("f3_below", 32'(bus.req_below), 32'd1);
    chk("f3_here", 32'(bus.req_here), 32'd0);
    bus.current_floor = 4'd6;
    #1;
    chk("f6_here", 32'(bus.req_here), 32'd1);
    chk("f6_above", 32'(bus.req_above), 32'd0);
    chk("f6_below", 32'(bus.req_below), 32'd1);
    bus.current_floor = 4'd0;
    #1;
    chk("f0_below", 32'(bus.req_below), 32'd0);
    chk("f0_above", 32'(bus.req_above), 32'd1);
    bus.current_floor = 4'd9;
    #1;
    chk("f9_above", 32'(bus.req_above), 32'd0);
    chk("f9_here", 32'(bus.req_here), 32'd0);
    chk("f9_below", 32'(bus.req_below), 32'd1);
    bus.current_floor = 4'd3;

    // Async reset mid-debounce
    bus.btn_in[2] = 1'b1;
    tick(3);
    an_reset = 1'b0;
    #1;
    chk_all("mid_rst", 8'h00, 8'h00, 8'h00);
    chk("mid_rst_above", 32'(bus.req_above), 32'd0);
    chk("mid_rst_below", 32'(bus.req_below), 32'd0);
    bus.btn_in = '0;
    tick(1);
    an_reset = 1'b1;
    tick(12);
    chk_all("post_rst", 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
Parametrised successor to the elevator button-register block, for an N-floor car. It synchronises and debounces every cabin and landing button, and latches each one as an active request. Cabin buttons toggle; landing buttons set only. Requests are cleared by an arrival/service strobe from the car controller. It also gives the controller above/below/here request summaries relative to the current floor.

Parameters:
FLOORS, 8, number of floors (2..16)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a button level change (>=1)
FLOOR_W, 4, width of floor index ports; must satisfy 2^FLOOR_W >= FLOORS

Ports:
clock  in  1  system clock, all state on rising edge
an_reset  in  1  asynchronous active-low reset
buttons_block  in  1  1 = discard new press events (clears still honoured)
btn_in  in  FLOORS  raw cabin buttons, bit i = floor i
btn_up_out  in  FLOORS  raw landing "up" buttons; bit FLOORS-1 ignored
btn_down_out  in  FLOORS  raw landing "down" buttons; bit 0 ignored
arrive_valid  in  1  one-cycle strobe: car serviced floor arrive_floor
arrive_floor  in  FLOOR_W  serviced floor index
arrive_dir  in  2  bit0 = clear up request, bit1 = clear down request; cabin request always cleared
current_floor  in  FLOOR_W  car position for summary outputs
active_in_levels  out  FLOORS  latched cabin requests
active_out_up_levels  out  FLOORS  latched landing up requests; bit FLOORS-1 constant 0
active_out_down_levels  out  FLOORS  latched landing down requests; bit 0 constant 0
any_request  out  1  OR of all active bits
req_above  out  1  any active bit at floor > current_floor
req_below  out  1  any active bit at floor < current_floor
req_here  out  1  any active bit at floor == current_floor

Behaviour:
- Reset (an_reset=0, async): synchronisers, debounce counters, debounced levels, previous-debounced levels and all active bits go to 0. All outputs read 0 while reset is held and after release.
- Per raw button (3*FLOORS channels; the two ignored bits are tied off internally): 2-FF synchroniser, then the debounce stage.
- Debounce: counter width ceil(log2(DEBOUNCE_CYCLES+1)).
  - Synchronised value == debounced value: counter clears to 0.
  - Values differ and counter == DEBOUNCE_CYCLES-1: debounced takes the new value and counter clears.
  - Values differ otherwise: counter increments.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes the debounced level.
- Press event: debounced 0->1, detected against a registered previous-debounced copy. It is a one-cycle internal pulse; the release edge generates nothing.
- Latency: raw input first sampled high at edge 1 and held. The active bit changes at edge DEBOUNCE_CYCLES+3 (edge 7 for default), visible right after that edge.
- Cabin press (buttons_block=0): active_in_levels[i] toggles, giving press-to-request and press-again-to-cancel.
- Landing press (buttons_block=0): sets the bit; it is never cleared by another press.
- buttons_block=1 in the event cycle: the event is lost, not deferred. Debounce continues, so a held button does not fire when the block drops.
- Clear: arrive_valid=1 with arrive_floor < FLOORS at edge k.
  - Clears active_in_levels[f].
  - Clears active_out_up_levels[f] if arrive_dir[0]=1.
  - Clears active_out_down_levels[f] if arrive_dir[1]=1.
  - arrive_floor >= FLOORS: no effect.
- Simultaneous clear and press on the same bit in the same cycle: clear wins, bit = 0, press discarded. Clear on a bit that is already 0 has no effect.
- Summaries: combinational from the active registers and current_floor. current_floor >= FLOORS: req_above=0, req_here=0, req_below = any_request.
- No other state; bits hold indefinitely until toggled or cleared.

Test Plan:
- Reset then idle, FLOORS=8, DEBOUNCE_CYCLES=4 -> all outputs 0. Hold btn_in[3]=1 from edge 1 -> active_in_levels=8'h08 after edge 7, never earlier.
- Pulse btn_up_out[2] high for 3 cycles -> no change. Pulse it for 6 cycles -> active_out_up_levels=8'h04. Second identical pulse -> still 8'h04.
- Two separate debounced presses of btn_in[5] -> bit 5 goes 1 then 0. With buttons_block=1 during the second press event -> bit stays 1.
- active_out_down_levels[6]=1 and active_in_levels[6]=1, arrive_valid with arrive_floor=6, arrive_dir=2'b01 -> cabin bit 6 cleared, down bit 6 still 1. Repeat with 2'b10 -> down bit 6 cleared.
- Clear strobe at floor 4 (arrive_dir=2'b11) on the same edge a cabin press event for floor 4 fires -> active_in_levels[4]=0. arrive_floor=9 -> no bits change.
- Requests at floors 1 and 6, current_floor=3 -> req_above=1, req_below=1, req_here=0. current_floor=6 -> req_here=1, req_above=0. Assert an_reset=0 mid-debounce -> all outputs 0 immediately, no press fires after release if the button is released first.
